approx_err_monitor: RTL and testbench
=====================================

Name: approx_err_monitor

Overview:
- Consumer-side companion to the approximate ripple-carry adders. It accepts operand pairs together with the approximate adder's (WIDTH+1)-bit result through a valid/ready handshake.
- It recomputes the exact sum and accumulates error metrics over a programmed number of samples: sum of absolute error, maximum absolute error, and erroneous-sample count.
- It sits between a stimulus source/DUT adder and a host readout, and is used for on-chip MAE/WCE/ER characterisation of adder variants.

Parameters:
- WIDTH, 16, operand width; the approximate result is WIDTH+1 bits.
- ACC_W, 48, width of the absolute-error accumulator.
- CNT_W, 32, width of the sample counters and of sample_limit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a measurement run.
- sample_limit  input  CNT_W  number of samples in a run; latched on start.
- in_valid  input  1  sample present.
- in_ready  output  1  monitor accepts a sample this cycle.
- in_a  input  WIDTH  operand IN1.
- in_b  input  WIDTH  operand IN2.
- in_approx  input  WIDTH+1  approximate adder Out.
- busy  output  1  run in progress.
- done  output  1  high from run completion until the next start or rst.
- sum_abs_err  output  ACC_W  sum of |exact - approx|, saturating.
- max_abs_err  output  WIDTH+1  largest |exact - approx| seen in the run.
- err_count  output  CNT_W  samples with nonzero error.
- sample_count  output  CNT_W  samples accumulated.

Behaviour:
- FSM states: IDLE, RUN, DRAIN, DONE. Reset puts the FSM in IDLE and clears all outputs, counters and pipeline valids to 0.
- IDLE/DONE + start: latch sample_limit, clear all metrics, go to RUN. If the latched limit is 0, go directly to DRAIN instead.
- start while in RUN or DRAIN is ignored.
- in_ready = 1 only in RUN. A transfer occurs on in_valid & in_ready.
- RUN: count accepted samples. The cycle the accepted count reaches the limit, go to DRAIN; in_ready drops on the next cycle. No sample beyond the limit is ever accepted.
- Pipeline stage 1 (registered on transfer): exact = in_a + in_b, zero-extended to WIDTH+1. diff = |exact - in_approx|, computed in WIDTH+2-bit signed arithmetic and taken as a WIDTH+1-bit magnitude. Also register nz = (diff != 0).
- Pipeline stage 2 (on stage-1 valid):
  - sum_abs_err += diff, saturating at all-ones.
  - max_abs_err = max(max_abs_err, diff).
  - err_count += nz.
  - sample_count += 1.
- Latency: a sample is reflected in the metrics 2 cycles after its transfer.
- DRAIN: wait until both stage valids are 0, then go to DONE and assert done.
- DONE: metrics hold stable until the next start.
- busy = 1 in RUN and DRAIN.
- Counters never wrap. The limit bounds sample_count; CNT_W bits are sufficient.
- rst mid-run: abort immediately. All state is cleared and any in-flight pipeline sample is discarded.
- Back-to-back transfers every cycle are supported (throughput 1/cycle).
- in_approx wider than the exact result (e.g. MSB set with small operands) is legal; the absolute value covers the case approx > exact.

Decomposition:
- Shared package approx_pkg holds:
  - default WIDTH/ACC_W/CNT_W constants;
  - the FSM state enum mon_state_t {IDLE, RUN, DRAIN, DONE};
  - a function abs_diff(exact, approx).
- One sub-module, err_metric_acc, holds stage 2: accumulate, max, counts and saturation. Its inputs are diff, nz, valid and clear. The top level holds the FSM, handshake and stage 1.

Test Plan:
- start, limit=1; sample a=0, b=0, approx=2 (the value the 2-LSB approximate-cell adder produces for 0+0) -> done after drain; sum_abs_err=2, max=2, err_count=1, sample_count=1.
- limit=3, back-to-back samples (3,3,approx 3), (4,8,approx 14), (5,5,approx 10) -> sum=5, max=3, err_count=2, sample_count=3; in_ready low from the 4th cycle onward.
- limit=0 start -> DONE within 2 cycles; all metrics 0; in_ready never high.
- in_valid toggling randomly with limit=100 of exact samples (approx = a+b) -> sum=0, err_count=0, sample_count=100, exactly 100 transfers.
- a=65535, b=65535, approx=0 -> diff=131070, max_abs_err=131070. Preload the accumulator near all-ones via a reduced-ACC_W build (ACC_W=17) -> sum saturates at 131071.
- rst asserted 1 cycle after a transfer in RUN -> next cycle the FSM is IDLE, all outputs 0, and no metric reflects the in-flight sample; a subsequent start runs normally.

Source files
------------

// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder error monitor: default sizes,
// FSM state encoding and the absolute-difference helper.
package approx_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ACC_W = 48;
  localparam int DEF_CNT_W = 32;
  localparam int ABS_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

  // Operands are zero-extended by the caller; one extra sign bit lets the
  // approximate result exceed the exact one without wrapping.
  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] exact,
                                                input logic [ABS_W-1:0] approx);
    logic signed [ABS_W:0] d;
    d = $signed({1'b0, exact}) - $signed({1'b0, approx});
    return d[ABS_W] ? ABS_W'(-d) : d[ABS_W-1:0];
  endfunction

endpackage

// File: rtl/err_metric_acc.sv
// Stage 2 of the monitor: saturating error-sum, running maximum and the
// error/sample counters, cleared at the start of every run.
module err_metric_acc
  import approx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH:0]   diff,
  input  logic             nz,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH:0]   max_abs_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count
);

  logic [ACC_W:0] sum_wide;

  assign sum_wide = {1'b0, sum_abs_err} + (ACC_W+1)'(diff);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
      err_count    <= '0;
      sample_count <= '0;
    end else if (valid) begin
      // A carry out of the accumulator pins it at all-ones rather than wrapping.
      sum_abs_err  <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
      if (diff > max_abs_err) max_abs_err <= diff;
      err_count    <= err_count + CNT_W'(nz);
      sample_count <= sample_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Measures MAE/WCE/ER of an approximate adder: run-control FSM, valid/ready
// intake and stage 1 (exact sum and |exact - approx|) feeding err_metric_acc.
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] sample_limit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH:0]   max_abs_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count
);

  mon_state_t       state, state_nx;
  logic [CNT_W-1:0] limit_q, accept_cnt, accept_nx;
  logic             xfer, start_ok;
  logic [WIDTH:0]   exact, diff;
  logic             s1_valid, s1_nz, s2_valid;
  logic [WIDTH:0]   s1_diff;

  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign accept_nx = accept_cnt + CNT_W'(1);

  assign exact = {1'b0, in_a} + {1'b0, in_b};
  assign diff  = (WIDTH+1)'(abs_diff(ABS_W'(exact), ABS_W'(in_approx)));

  // NOTE: every default is assigned first so no path leaves state_nx unassigned
  // and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = (sample_limit == '0) ? DRAIN : RUN;
      RUN:        if (xfer && (accept_nx == limit_q)) state_nx = DRAIN;
      DRAIN:      if (!s1_valid && !s2_valid) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      limit_q    <= '0;
      accept_cnt <= '0;
      s1_valid   <= 1'b0;
      s1_diff    <= '0;
      s1_nz      <= 1'b0;
      s2_valid   <= 1'b0;
    end else begin
      state    <= state_nx;
      s1_valid <= xfer;
      s2_valid <= s1_valid;
      if (start_ok) begin
        limit_q    <= sample_limit;
        accept_cnt <= '0;
      end else if (xfer) begin
        accept_cnt <= accept_nx;
      end
      if (xfer) begin
        s1_diff <= diff;
        s1_nz   <= (diff != '0);
      end
    end
  end

  err_metric_acc #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_ok),
    .valid       (s1_valid),
    .diff        (s1_diff),
    .nz          (s1_nz),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err),
    .err_count   (err_count),
    .sample_count(sample_count)
  );

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench: each run pushes its expected metrics; a monitor pops and
// compares on every rising edge of done. A 17-bit-accumulator twin shares stimulus.
module tb_approx_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] sample_limit = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic [16:0] in_approx = '0;

  logic        in_ready, busy, done;
  logic [47:0] sum_abs_err;
  logic [16:0] max_abs_err;
  logic [31:0] err_count, sample_count;

  logic        in_ready_s, busy_s, done_s;
  logic [16:0] sum_s, max_s;
  logic [31:0] errc_s, cnt_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [47:0] sum;
    logic [16:0] sum_small;
    logic [16:0] max;
    logic [31:0] errc;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  approx_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .sample_limit(sample_limit),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(busy), .done(done),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
    .err_count(err_count), .sample_count(sample_count)
  );

  approx_err_monitor #(.ACC_W(17)) dut_small (
    .clk(clk), .rst(rst), .start(start), .sample_limit(sample_limit),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(busy_s), .done(done_s),
    .sum_abs_err(sum_s), .max_abs_err(max_s),
    .err_count(errc_s), .sample_count(cnt_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: compare metrics of both instances whenever a run completes.
  initial begin
    logic done_q = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done sample_count=%0d", sample_count);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_sum"},       64'(sum_abs_err),  64'(e.sum));
          check({e.name, "_sum_small"}, 64'(sum_s),        64'(e.sum_small));
          check({e.name, "_max"},       64'(max_abs_err),  64'(e.max));
          check({e.name, "_errc"},      64'(err_count),    64'(e.errc));
          check({e.name, "_cnt"},       64'(sample_count), 64'(e.cnt));
        end
      end
      done_q = done;
    end
  end

  task automatic push(input string name, input logic [47:0] sum, input logic [16:0] sum_small,
                      input logic [16:0] max, input logic [31:0] errc, input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.sum = sum; e.sum_small = sum_small;
    e.max = max; e.errc = errc; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic do_start(input logic [31:0] limit);
    start = 1'b1;
    sample_limit = limit;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Holds the sample until it is accepted; returns at posedge+1 after the transfer.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_approx = ap;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout a=%0d b=%0d in_ready=%0d", a, b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL %s_done_timeout done=%0d budget=%0d", name, done, budget);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int xfers;
    int cyc;
    logic saw_ready;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_sum", 64'(sum_abs_err), 64'd0);
    check("rst_cnt", 64'(sample_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single sample from the 2-LSB approximate cell: 0+0 -> 2.
    push("t1", 48'd2, 17'd2, 17'd2, 32'd1, 32'd1);
    do_start(32'd1);
    send(16'd0, 16'd0, 17'd2);
    wait_done("t1", 20);

    // Back-to-back; the second sample has approx > exact.
    push("t2", 48'd5, 17'd5, 17'd3, 32'd2, 32'd3);
    do_start(32'd3);
    send(16'd3, 16'd3, 17'd3);
    send(16'd4, 16'd8, 17'd14);
    send(16'd5, 16'd5, 17'd10);
    check("t2_ready_after_limit", 64'(in_ready), 64'd0);
    check("t2_busy_drain", 64'(busy), 64'd1);
    wait_done("t2", 20);

    // Zero limit: straight to DRAIN, DONE within two cycles, never ready.
    push("t3", 48'd0, 17'd0, 17'd0, 32'd0, 32'd0);
    do_start(32'd0);
    saw_ready = in_ready;
    @(posedge clk); #1;
    saw_ready = saw_ready | in_ready;
    check("t3_done_in_2", 64'(done), 64'd1);
    check("t3_never_ready", 64'(saw_ready), 64'd0);
    wait_done("t3", 5);

    // 100 exact samples with in_valid toggling; valid keeps toggling past the
    // limit to show nothing extra is accepted.
    push("t4", 48'd0, 17'd0, 17'd0, 32'd0, 32'd100);
    do_start(32'd100);
    xfers = 0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_approx = {1'b0, in_a} + {1'b0, in_b};
      @(negedge clk);
      if (in_valid && in_ready) xfers++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("t4_transfers", 64'(xfers), 64'd100);
    wait_done("t4", 20);

    // Worst-case error twice: 17-bit accumulator saturates, 48-bit does not.
    push("t5", 48'd262140, 17'd131071, 17'd131070, 32'd2, 32'd2);
    do_start(32'd2);
    send(16'hFFFF, 16'hFFFF, 17'd0);
    send(16'hFFFF, 16'hFFFF, 17'd0);
    wait_done("t5", 20);

    // Reset one cycle after a transfer discards the in-flight sample.
    do_start(32'd5);
    send(16'd10, 16'd20, 17'd25);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("t6_sum", 64'(sum_abs_err), 64'd0);
    check("t6_max", 64'(max_abs_err), 64'd0);
    check("t6_errc", 64'(err_count), 64'd0);
    check("t6_cnt", 64'(sample_count), 64'd0);

    // Normal run after the abort: 100+200 vs 260.
    push("t7", 48'd40, 17'd40, 17'd40, 32'd1, 32'd1);
    do_start(32'd1);
    send(16'd100, 16'd200, 17'd260);
    wait_done("t7", 20);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
